// File: rtl/fetch_unit_if.sv
// fetch_unit_if: CPU-side instruction bus (req/addr_ok/data_ok handshake).
interface fetch_unit_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iaddr_ok;
  logic        idata_ok;
  logic [31:0] idata;
  modport master(output ireq, iaddr, input iaddr_ok, idata_ok, idata);
  modport slave(input ireq, iaddr, output iaddr_ok, idata_ok, idata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS front end; owns fetch PC, issues ibus reads, feeds the decode record.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        ib,
  output logic                d_valid,
  output logic [31:0]         d_pc,
  output logic [31:0]         d_instr,
  output logic                d_adel,
  input  logic                pcf1,
  input  logic                ifj,
  input  logic [31:0]         pc_decode,
  input  logic                exc_valid,
  input  logic [31:0]         exc_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, BUF} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, buf_q, buf_d;
  logic [31:0] br_slot_q, br_slot_d, br_tgt_q, br_tgt_d;
  logic [31:0] d_pc_q, d_pc_d, d_instr_q, d_instr_d;
  logic        drop_q, drop_d, br_pend_q, br_pend_d, d_valid_q, d_valid_d, d_adel_q, d_adel_d;
  logic        consume, dfree, take_br, issue, adel_load, hs, adv, load, ld_adel, eff_pend;
  logic [31:0] eff_slot, eff_tgt, adv_addr, adv_next, ld_pc, ld_instr;
  always_comb begin
    consume   = d_valid_q && !pcf1;
    dfree     = !d_valid_q || !pcf1;
    take_br   = consume && ifj;
    issue     = state_q == IDLE && !exc_valid && dfree && fetch_pc_q[1:0] == 2'b00;
    adel_load = state_q == IDLE && !exc_valid && dfree && fetch_pc_q[1:0] != 2'b00;
    hs        = ib.iaddr_ok && (issue || (state_q == REQ && !drop_q));
    adv       = (hs || adel_load) && !exc_valid;
    adv_addr  = state_q == REQ ? addr_q : fetch_pc_q;
    // A branch resolving this cycle must steer a slot handshake happening in the same cycle
    eff_pend  = br_pend_q || take_br;
    eff_slot  = take_br ? d_pc_q + 32'd4 : br_slot_q;
    eff_tgt   = take_br ? pc_decode : br_tgt_q;
    adv_next  = eff_pend && adv_addr == eff_slot ? eff_tgt : adv_addr + 32'd4;
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    drop_d    = drop_q;
    load      = 1'b0;
    ld_pc     = addr_q;
    ld_instr  = buf_q;
    ld_adel   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          addr_d  = fetch_pc_q;
          state_d = ib.iaddr_ok ? WAIT : REQ;
        end else if (adel_load) begin
          load     = 1'b1;
          ld_pc    = fetch_pc_q;
          ld_instr = 32'd0;
          ld_adel  = 1'b1;
        end
      end
      REQ: begin
        drop_d  = drop_q || exc_valid;
        state_d = ib.iaddr_ok ? WAIT : REQ;
      end
      WAIT: begin
        if (ib.idata_ok) begin
          drop_d  = 1'b0;
          state_d = IDLE;
          if (!drop_q && !exc_valid) begin
            load     = dfree;
            ld_instr = ib.idata;
            buf_d    = ib.idata;
            state_d  = dfree ? IDLE : BUF;
          end
        end else begin
          drop_d = drop_q || exc_valid;
        end
      end
      BUF: begin
        state_d = exc_valid || dfree ? IDLE : BUF;
        load    = !exc_valid && dfree;
      end
    endcase
    d_valid_d  = exc_valid ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : d_valid_q;
    d_pc_d     = load ? ld_pc : d_pc_q;
    d_instr_d  = load ? ld_instr : d_instr_q;
    d_adel_d   = load ? ld_adel : d_adel_q;
    // Slot already handshaken means the outstanding/buffered word is the slot: redirect now
    fetch_pc_d = exc_valid ? exc_pc : adv ? adv_next :
                 take_br && fetch_pc_q != eff_slot ? pc_decode : fetch_pc_q;
    br_pend_d  = exc_valid || adv ? 1'b0 : take_br && fetch_pc_q == eff_slot ? 1'b1 : br_pend_q;
    br_slot_d  = take_br ? eff_slot : br_slot_q;
    br_tgt_d   = take_br ? eff_tgt : br_tgt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'd0;
      buf_q      <= 32'd0;
      drop_q     <= 1'b0;
      br_pend_q  <= 1'b0;
      br_slot_q  <= 32'd0;
      br_tgt_q   <= 32'd0;
      d_valid_q  <= 1'b0;
      d_pc_q     <= 32'd0;
      d_instr_q  <= 32'd0;
      d_adel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      drop_q     <= drop_d;
      br_pend_q  <= br_pend_d;
      br_slot_q  <= br_slot_d;
      br_tgt_q   <= br_tgt_d;
      d_valid_q  <= d_valid_d;
      d_pc_q     <= d_pc_d;
      d_instr_q  <= d_instr_d;
      d_adel_q   <= d_adel_d;
    end
  end
  assign ib.ireq  = !reset && (state_q == REQ || issue);
  assign ib.iaddr = state_q == REQ ? addr_q : fetch_pc_q;
  assign d_valid  = d_valid_q;
  assign d_pc     = d_pc_q;
  assign d_instr  = d_instr_q;
  assign d_adel   = d_adel_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random ibus slave and decode stage checked against a program-order PC model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  logic        clk = 0, reset = 1;
  logic        d_valid, d_adel, pcf1 = 0, ifj = 0, exc_valid = 0;
  logic [31:0] d_pc, d_instr, pc_decode = 0, exc_pc = 0;
  fetch_unit_if bus();
  fetch_unit dut (.clk(clk), .reset(reset), .ib(bus.master), .d_valid(d_valid), .d_pc(d_pc),
                  .d_instr(d_instr), .d_adel(d_adel), .pcf1(pcf1), .ifj(ifj),
                  .pc_decode(pc_decode), .exc_valid(exc_valid), .exc_pc(exc_pc));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  bit rnd = 0, drv_pcf1 = 0, drv_exc = 0, drv_ifj = 0, jmp_en = 0;
  logic [31:0] drv_excpc = 0, drv_pcd = 0, jmp_at = 0, jmp_to = 0;
  int acc_pct = 100, max_lat = 0, lat_s = 0;
  bit pend_s = 0, prev_wait = 0, prev_hold = 0, slot_pend = 0, ireq_s = 0;
  logic [31:0] paddr = 0, prev_addr = 0, hold_pc = 0, hold_in = 0, exp_pc = RST_PC, tgt = 0;
  logic [31:0] hs_q[$], cons_q[$];
  logic [31:0] exc_tab [5] = '{32'hBFC0_0380, 32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_0103, 32'h0000_2000};
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    pend_s = 0; prev_wait = 0; prev_hold = 0; slot_pend = 0; exp_pc = RST_PC;
    hs_q.delete(); cons_q.delete();
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq", bus.ireq, 0);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_dpc", d_pc, 0);
    chk("rst_dinstr", d_instr, 0);
    chk("rst_dadel", d_adel, 0);
    reset = 0;
    model_reset();
  endtask
  task automatic tick();
    @(negedge clk);
    bus.idata_ok = 0;
    bus.idata = 0;
    if (pend_s) begin
      if (lat_s == 0) begin
        bus.idata_ok = 1;
        bus.idata = memf(paddr);
        pend_s = 0;
      end else lat_s--;
    end
    if (rnd) begin
      drv_pcf1  = ($urandom % 4) == 0;
      drv_exc   = ($urandom % 50) == 0;
      drv_excpc = exc_tab[$urandom % 5];
      drv_ifj   = ($urandom % 4) == 0;
      drv_pcd   = 32'h1000 + ($urandom_range(0, 255) << 2);
    end
    pcf1 = drv_pcf1;
    exc_valid = drv_exc;
    exc_pc = drv_excpc;
    ifj = drv_ifj && d_valid && !slot_pend;
    pc_decode = drv_pcd;
    if (jmp_en && d_valid && d_pc == jmp_at && !exc_valid) begin
      ifj = 1; pc_decode = jmp_to; pcf1 = 0; jmp_en = 0;
    end
    #1;
    ireq_s = bus.ireq;
    if (prev_wait) begin
      chk("req_held", bus.ireq, 1);
      chk("addr_held", bus.iaddr, prev_addr);
    end
    if (pend_s) chk("one_out", bus.ireq, 0);
    bus.iaddr_ok = bus.ireq && ($urandom_range(1, 100) <= acc_pct);
    if (bus.iaddr_ok) begin
      chk("hs_align", {30'd0, bus.iaddr[1:0]}, 0);
      hs_q.push_back(bus.iaddr);
      pend_s = 1;
      paddr = bus.iaddr;
      lat_s = rnd ? $urandom_range(0, max_lat) : max_lat;
    end
    prev_wait = bus.ireq && !bus.iaddr_ok;
    prev_addr = bus.iaddr;
    if (prev_hold) begin
      chk("hold_v", d_valid, 1);
      chk("hold_pc", d_pc, hold_pc);
      chk("hold_in", d_instr, hold_in);
    end
    prev_hold = d_valid && pcf1 && !exc_valid;
    hold_pc = d_pc;
    hold_in = d_instr;
    if (exc_valid) begin
      exp_pc = exc_pc;
      slot_pend = 0;
    end else if (d_valid && !pcf1) begin
      chk("d_pc", d_pc, exp_pc);
      chk("d_adel", d_adel, exp_pc[1:0] != 2'b00);
      chk("d_instr", d_instr, exp_pc[1:0] != 2'b00 ? 32'd0 : memf(exp_pc));
      cons_q.push_back(d_pc);
      if (slot_pend) begin
        exp_pc = tgt;
        slot_pend = 0;
      end else begin
        if (ifj) begin
          slot_pend = 1;
          tgt = pc_decode;
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask
  initial begin
    int n;
    logic [31:0] old;
    bus.iaddr_ok = 0; bus.idata_ok = 0; bus.idata = 0;
    do_reset();
    acc_pct = 100; max_lat = 0;
    tick();
    chk("first_req", ireq_s, 1);
    repeat (19) tick();
    chk("t1_hs_n", hs_q.size() >= 3, 1);
    if (hs_q.size() >= 3) begin
      chk("t1_hs0", hs_q[0], 32'hBFC0_0000);
      chk("t1_hs1", hs_q[1], 32'hBFC0_0004);
      chk("t1_hs2", hs_q[2], 32'hBFC0_0008);
    end
    chk("t1_tput", cons_q.size() >= 9, 1);
    n = cons_q.size();
    drv_exc = 1; drv_excpc = 32'h100;
    tick();
    drv_exc = 0;
    jmp_en = 1; jmp_at = 32'h100; jmp_to = 32'h200;
    for (int i = 0; i < 60 && cons_q.size() < n + 3; i++) tick();
    chk("t2_to", cons_q.size() >= n + 3, 1);
    if (cons_q.size() >= n + 3) begin
      chk("t2_a", cons_q[n], 32'h100);
      chk("t2_b", cons_q[n+1], 32'h104);
      chk("t2_c", cons_q[n+2], 32'h200);
    end
    max_lat = 2;
    repeat (3) tick();
    drv_pcf1 = 1;
    repeat (3) tick();
    drv_pcf1 = 0;
    repeat (12) tick();
    acc_pct = 0;
    for (int i = 0; i < 20 && !prev_wait; i++) tick();
    chk("t4_req", prev_wait, 1);
    old = prev_addr;
    n = hs_q.size();
    drv_exc = 1; drv_excpc = 32'hBFC0_0380;
    tick();
    drv_exc = 0;
    tick();
    acc_pct = 100;
    for (int i = 0; i < 40 && hs_q.size() < n + 2; i++) tick();
    chk("t4_to", hs_q.size() >= n + 2, 1);
    if (hs_q.size() >= n + 2) begin
      chk("t4_stale", hs_q[n], old);
      chk("t4_next", hs_q[n+1], 32'hBFC0_0380);
    end
    repeat (6) tick();
    n = cons_q.size();
    drv_exc = 1; drv_excpc = 32'h103;
    tick();
    drv_exc = 0;
    for (int i = 0; i < 20 && cons_q.size() < n + 2; i++) tick();
    chk("t5_to", cons_q.size() >= n + 2, 1);
    if (cons_q.size() >= n + 2) begin
      chk("t5_pc", cons_q[n], 32'h103);
      chk("t5_pc2", cons_q[n+1], 32'h107);
    end
    drv_exc = 1; drv_excpc = 32'h2000;
    tick();
    drv_exc = 0;
    rnd = 1; acc_pct = 70; max_lat = 3;
    repeat (3000) tick();
    rnd = 0; drv_pcf1 = 0; drv_exc = 0; drv_ifj = 0; acc_pct = 100; max_lat = 3;
    for (int i = 0; i < 30 && !pend_s; i++) tick();
    chk("t6_pend", pend_s, 1);
    tick();
    #1 reset = 1;
    #1;
    chk("t6_ireq", bus.ireq, 0);
    chk("t6_dvalid", d_valid, 0);
    chk("t6_dpc", d_pc, 0);
    do_reset();
    pend_s = 1; lat_s = 0; paddr = 32'hDEAD_0000; acc_pct = 0;
    tick();
    chk("t6_first_req", ireq_s, 1);
    acc_pct = 100; max_lat = 0;
    repeat (20) tick();
    chk("t6_cons", cons_q.size() >= 2, 1);
    if (cons_q.size() >= 2) chk("t6_pc0", cons_q[0], RST_PC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
